mul_sequencer: RTL

Iterative 32×32 multiply unit driven by the multicycle controller when it decodes a multiply instruction (`is_mul`). It accepts operands from the register-file read ports on a start pulse and runs a radix-2 shift-add sequence over WIDTH cycles. It returns a 32- or 64-bit product with N/Z flags and a one-cycle done pulse. While the unit runs, the controller holds its multiply state and stalls `PCWrite`/`RegWrite`.

---
 rtl/mul_pkg.sv | 25 ++
 rtl/mul_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mul_pkg;

  localparam int MUL_WIDTH = 32;

  localparam logic [1:0] MUL_OP_MUL   = 2'b00;
  localparam logic [1:0] MUL_OP_UMULL = 2'b01;
  localparam logic [1:0] MUL_OP_SMULL = 2'b10;
  localparam logic [1:0] MUL_OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

  // Width of a counter that must hold 0..w-1 (at least one bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int MUL_CNT_W = cnt_width(MUL_WIDTH);

endpackage

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiplier: fixed WIDTH+3 cycle turnaround, start ignored unless idle.
// SMULL runs on magnitudes and fixes the sign in FIX; all outputs registered.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       flags
);

  localparam int CW = cnt_width(WIDTH);

  mul_state_e         state;
  logic [1:0]         op_q;
  logic               neg;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               is_smull;
  logic               is_long;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    is_smull = (op == MUL_OP_SMULL);
    is_long  = (op_q == MUL_OP_UMULL) || (op_q == MUL_OP_SMULL);
    // The most negative value maps onto itself, which reads correctly as 2^(WIDTH-1) unsigned.
    abs_a    = a[WIDTH-1] ? (~a + 1'b1) : a;
    abs_b    = b[WIDTH-1] ? (~b + 1'b1) : b;
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    acc_step = {sum, acc[WIDTH-1:1]};
    prod     = neg ? (~acc + 1'b1) : acc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      op_q      <= MUL_OP_MUL;
      neg       <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op;
            mcand  <= is_smull ? abs_a : a;
            mplier <= is_smull ? abs_b : b;
            neg    <= is_smull && (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FIX: begin
          result_lo <= prod[WIDTH-1:0];
          if (is_long) begin
            result_hi <= prod[2*WIDTH-1:WIDTH];
            flags     <= {prod[2*WIDTH-1], (prod == '0)};
          end else begin
            result_hi <= '0;
            flags     <= {prod[WIDTH-1], (prod[WIDTH-1:0] == '0)};
          end
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
